// File: rtl/singlecycle_pkg.sv
// Shared types for the single-cycle RV32I core: load/store size encoding,
// LSU FSM states and byte-lane helper functions.
package singlecycle_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } LSUOp_e;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ   = 3'd1,
    LSU_WAIT  = 3'd2,
    LSU_REQ2  = 3'd3,
    LSU_WAIT2 = 3'd4,
    LSU_DONE  = 3'd5
  } LSUState_e;

  // Access size as a byte mask; unknown encodings behave as a word.
  function automatic logic [3:0] size_mask(input logic [2:0] op);
    logic [3:0] m;
    case (op)
      LSU_B, LSU_BU: m = 4'b0001;
      LSU_H, LSU_HU: m = 4'b0011;
      default:       m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] op, input logic [1:0] off);
    return {4'b0000, size_mask(op)} << off;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic [3:0] m;
    logic       r;
    m = size_mask(op);
    if (m == 4'b0001) begin
      r = 1'b0;
    end else if (m == 4'b0011) begin
      r = off[0];
    end else begin
      r = (off != 2'b00);
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Combinational byte-lane formatting: byte enables and store lanes for both
// beats, plus load data extraction and sign/zero extension.
module lsu_lane_fmt
  import singlecycle_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] ld_data
);

  logic [7:0]  mask8_s;
  logic [4:0]  sh_amt_s;
  logic [63:0] st_shift_s;
  logic [63:0] ld_shift_s;
  logic [31:0] st_rep_s;

  assign mask8_s    = lane_mask(op, off);
  assign be_lo      = mask8_s[3:0];
  assign be_hi      = mask8_s[7:4];
  assign sh_amt_s   = {off, 3'b000};
  assign st_shift_s = {32'h0000_0000, st_data} << sh_amt_s;
  assign ld_shift_s = {rdata_hi, rdata_lo} >> sh_amt_s;
  assign wdata_hi   = st_shift_s[63:32];

  // Replicated lanes for aligned stores, shifted lanes when a store straddles words
  always_comb begin
    st_rep_s = st_data;
    case (op)
      LSU_B, LSU_BU: st_rep_s = {4{st_data[7:0]}};
      LSU_H, LSU_HU: st_rep_s = {2{st_data[15:0]}};
      default:       st_rep_s = st_data;
    endcase
    if (is_misaligned(op, off)) begin
      wdata_lo = st_shift_s[31:0];
    end else begin
      wdata_lo = st_rep_s;
    end
  end

  // Load extension from bit 7/15 depending on size and signedness
  always_comb begin
    ld_data = ld_shift_s[31:0];
    case (op)
      LSU_B:   ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
      LSU_BU:  ld_data = {24'h00_0000, ld_shift_s[7:0]};
      LSU_H:   ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
      LSU_HU:  ld_data = {16'h0000, ld_shift_s[15:0]};
      default: ld_data = ld_shift_s[31:0];
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: req/gnt/rvalid data-memory sequencer with core stall.
// Define LSU_SPLIT_MISALIGNED_EN to split misaligned accesses into two beats.
module lsu
  import singlecycle_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 32'd255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ld_req,
  input  logic        i_st_req,
  input  logic [2:0]  i_lsu_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  localparam logic [31:0] TO_LAST = 32'(WAIT_TIMEOUT - 32'd1);

  LSUState_e   state_r, state_nxt_s;
  logic [31:0] addr_r, data_r, rdata1_r, cnt_r, ld_data_r;
  logic [2:0]  op_r;
  logic        we_r, split_r, bus_err_r;
  logic        req_s, accept_s, cap_lo_s, ld_fin_s, to_fire_s, timeout_s, split_in_s;
  logic        busy_s, beat2_s;
  logic [31:0] word_addr_s, rd_lo_s, rd_hi_s, fmt_ld_s, wdata_lo_s, wdata_hi_s;
  logic [3:0]  be_lo_s, be_hi_s;
`ifdef LSU_SPLIT_MISALIGNED_EN
  logic [7:0]  mask_in_s;
`else
  logic        misal_s, trap_s;
`endif

  // Requests are ignored while reset is asserted so all outputs read 0
  assign req_s     = (i_ld_req | i_st_req) & i_rst_n;
  assign timeout_s = (WAIT_TIMEOUT != 32'd0) && (cnt_r == TO_LAST);
  assign busy_s    = (state_r == LSU_REQ) || (state_r == LSU_WAIT) ||
                     (state_r == LSU_REQ2) || (state_r == LSU_WAIT2);

`ifdef LSU_SPLIT_MISALIGNED_EN
  assign mask_in_s    = lane_mask(i_lsu_op, i_addr[1:0]);
  assign split_in_s   = |mask_in_s[7:4];
  assign o_misaligned = 1'b0;
`else
  assign misal_s      = is_misaligned(i_lsu_op, i_addr[1:0]);
  assign split_in_s   = 1'b0;
  assign o_misaligned = trap_s;
`endif

  // Next-state and per-cycle event decode
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    cap_lo_s    = 1'b0;
    ld_fin_s    = 1'b0;
    to_fire_s   = 1'b0;
`ifdef LSU_SPLIT_MISALIGNED_EN
`else
    trap_s      = 1'b0;
`endif
    case (state_r)
      LSU_IDLE: begin
        if (req_s) begin
`ifdef LSU_SPLIT_MISALIGNED_EN
          accept_s    = 1'b1;
          state_nxt_s = LSU_REQ;
`else
          if (misal_s) begin
            trap_s = 1'b1;
          end else begin
            accept_s    = 1'b1;
            state_nxt_s = LSU_REQ;
          end
`endif
        end else begin
          state_nxt_s = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        if (i_dmem_gnt) begin
          if (!we_r) state_nxt_s = LSU_WAIT;
          else if (split_r) state_nxt_s = LSU_REQ2;
          else state_nxt_s = LSU_DONE;
        end else if (timeout_s) begin
          to_fire_s   = 1'b1;
          state_nxt_s = LSU_DONE;
        end else begin
          state_nxt_s = LSU_REQ;
        end
      end
      LSU_WAIT: begin
        if (i_dmem_rvalid) begin
          if (split_r) begin
            cap_lo_s    = 1'b1;
            state_nxt_s = LSU_REQ2;
          end else begin
            ld_fin_s    = 1'b1;
            state_nxt_s = LSU_DONE;
          end
        end else if (timeout_s) begin
          to_fire_s   = 1'b1;
          state_nxt_s = LSU_DONE;
        end else begin
          state_nxt_s = LSU_WAIT;
        end
      end
`ifdef LSU_SPLIT_MISALIGNED_EN
      LSU_REQ2: begin
        if (i_dmem_gnt) begin
          if (we_r) state_nxt_s = LSU_DONE;
          else state_nxt_s = LSU_WAIT2;
        end else if (timeout_s) begin
          to_fire_s   = 1'b1;
          state_nxt_s = LSU_DONE;
        end else begin
          state_nxt_s = LSU_REQ2;
        end
      end
      LSU_WAIT2: begin
        if (i_dmem_rvalid) begin
          ld_fin_s    = 1'b1;
          state_nxt_s = LSU_DONE;
        end else if (timeout_s) begin
          to_fire_s   = 1'b1;
          state_nxt_s = LSU_DONE;
        end else begin
          state_nxt_s = LSU_WAIT2;
        end
      end
`else
`endif
      LSU_DONE: state_nxt_s = LSU_IDLE;
      default:  state_nxt_s = LSU_IDLE;
    endcase
  end

  // FSM state and timeout counter; the counter restarts on every state change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= LSU_IDLE;
      cnt_r   <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) cnt_r <= 32'd0;
      else if (busy_s) cnt_r <= cnt_r + 32'd1;
      else cnt_r <= 32'd0;
    end
  end

  // Latched request, first-beat read data and registered results
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_r    <= 32'd0;
      op_r      <= 3'd0;
      data_r    <= 32'd0;
      we_r      <= 1'b0;
      split_r   <= 1'b0;
      rdata1_r  <= 32'd0;
      ld_data_r <= 32'd0;
      bus_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r  <= i_addr;
        op_r    <= i_lsu_op;
        data_r  <= i_st_data;
        we_r    <= ~i_ld_req;
        split_r <= split_in_s;
      end
      if (cap_lo_s) rdata1_r <= i_dmem_rdata;
      if (ld_fin_s) ld_data_r <= fmt_ld_s;
      else if (to_fire_s && !we_r) ld_data_r <= 32'd0;
      bus_err_r <= to_fire_s;
    end
  end

  assign beat2_s = (state_r == LSU_REQ2);
  assign rd_lo_s = (state_r == LSU_WAIT2) ? rdata1_r : i_dmem_rdata;
  assign rd_hi_s = (state_r == LSU_WAIT2) ? i_dmem_rdata : 32'd0;

  lsu_lane_fmt u_fmt (
    .op       (op_r),
    .off      (addr_r[1:0]),
    .st_data  (data_r),
    .rdata_lo (rd_lo_s),
    .rdata_hi (rd_hi_s),
    .be_lo    (be_lo_s),
    .be_hi    (be_hi_s),
    .wdata_lo (wdata_lo_s),
    .wdata_hi (wdata_hi_s),
    .ld_data  (fmt_ld_s)
  );

  assign word_addr_s  = {addr_r[31:2], 2'b00} + (beat2_s ? 32'd4 : 32'd0);
  assign o_dmem_req   = (state_r == LSU_REQ) || beat2_s;
  assign o_dmem_we    = o_dmem_req & we_r;
  assign o_dmem_addr  = o_dmem_req ? word_addr_s : 32'd0;
  assign o_dmem_be    = o_dmem_req ? (beat2_s ? be_hi_s : be_lo_s) : 4'd0;
  assign o_dmem_wdata = o_dmem_we ? (beat2_s ? wdata_hi_s : wdata_lo_s) : 32'd0;
  assign o_stall      = accept_s | busy_s;
  assign o_done       = (state_r == LSU_DONE);
  assign o_bus_err    = bus_err_r;
  assign o_ld_data    = ld_data_r;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: loads, stores, lane formatting,
// misalignment (trap or split), timeout and asynchronous reset.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_req, st_req;
  logic [2:0]  lsu_op;
  logic [31:0] addr, st_data;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] ld_data;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  int          errors = 0;
  int          checks = 0;

  localparam logic [2:0]  LX_OP    [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b111};
  localparam logic [31:0] LX_ADDR  [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h104};
  localparam logic [31:0] LX_RDATA [6] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_7F00,
                                           32'h1234_F00D, 32'h0000_7F00, 32'hCAFE_BABE};
  localparam logic [3:0]  LX_BE    [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
  localparam logic [31:0] LX_EXP   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                                           32'h0000_F00D, 32'h0000_007F, 32'hCAFE_BABE};

  localparam logic [2:0]  SL_OP   [4] = '{3'b000, 3'b010, 3'b001, 3'b000};
  localparam logic [31:0] SL_ADDR [4] = '{32'h301, 32'h304, 32'h300, 32'h303};
  localparam logic [31:0] SL_DATA [4] = '{32'h0000_00A5, 32'hDEAD_BEEF, 32'h5555_BEEF, 32'h0000_007E};
  localparam logic [31:0] SL_WORD [4] = '{32'h300, 32'h304, 32'h300, 32'h300};
  localparam logic [3:0]  SL_BE   [4] = '{4'b0010, 4'b1111, 4'b0011, 4'b1000};
  localparam logic [31:0] SL_WD   [4] = '{32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'hBEEF_BEEF, 32'h7E7E_7E7E};

  localparam logic        MA_LD   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [2:0]  MA_OP   [4] = '{3'b010, 3'b001, 3'b101, 3'b010};
  localparam logic [31:0] MA_ADDR [4] = '{32'h101, 32'h203, 32'h105, 32'h302};

  always #5 clk = ~clk;

  lsu #(.WAIT_TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_req(ld_req), .i_st_req(st_req),
    .i_lsu_op(lsu_op), .i_addr(addr), .i_st_data(st_data),
    .o_stall(stall), .o_done(done), .o_ld_data(ld_data), .o_misaligned(misaligned),
    .o_bus_err(bus_err), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata)
  );

  task automatic idle_inputs();
    ld_req = 1'b0; st_req = 1'b0; lsu_op = 3'b010; addr = 32'h0; st_data = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({stall, done, misaligned, bus_err, dmem_req, dmem_we} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {stall, done, misaligned, bus_err, dmem_req, dmem_we}); end
    checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld_data: got %h want 0", ld_data); end
    checks++; if ({dmem_addr, dmem_be, dmem_wdata} !== 68'h0) begin errors++; $display("FAIL reset_bus: addr %h be %b wdata %h want 0", dmem_addr, dmem_be, dmem_wdata); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_lw();
    @(negedge clk); ld_req = 1'b1; lsu_op = 3'b010; addr = 32'h100; #1;
    checks++; if (stall !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL lw_c0: stall %b req %b want 1 0", stall, dmem_req); end
    @(negedge clk); dmem_gnt = 1'b1; #1;
    checks++; if ({dmem_req, dmem_we, stall} !== 3'b101 || dmem_addr !== 32'h100 || dmem_be !== 4'b1111) begin errors++; $display("FAIL lw_c1: req/we/stall %b addr %h be %b want 101 100 1111", {dmem_req, dmem_we, stall}, dmem_addr, dmem_be); end
    @(negedge clk); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8000_00F0; #1;
    checks++; if ({stall, dmem_req, done} !== 3'b100) begin errors++; $display("FAIL lw_c2: stall/req/done %b want 100", {stall, dmem_req, done}); end
    @(negedge clk); dmem_rvalid = 1'b0; dmem_rdata = 32'h0; #1;
    checks++; if ({done, stall, bus_err} !== 3'b100 || ld_data !== 32'h8000_00F0) begin errors++; $display("FAIL lw_c3: done/stall/err %b data %h want 100 800000f0", {done, stall, bus_err}, ld_data); end
    @(negedge clk); ld_req = 1'b0; #1;
    checks++; if ({done, dmem_req} !== 2'b00 || ld_data !== 32'h8000_00F0) begin errors++; $display("FAIL lw_c4_hold: done/req %b data %h want 00 800000f0", {done, dmem_req}, ld_data); end
  endtask

  task automatic test_load_ext();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); ld_req = 1'b1; lsu_op = LX_OP[i]; addr = LX_ADDR[i]; #1;
      @(negedge clk); dmem_gnt = 1'b1; #1;
      checks++; if (dmem_req !== 1'b1 || dmem_be !== LX_BE[i] || dmem_addr !== (LX_ADDR[i] & 32'hFFFF_FFFC)) begin errors++; $display("FAIL ld_ext_be[%0d]: req %b be %b addr %h want 1 %b %h", i, dmem_req, dmem_be, dmem_addr, LX_BE[i], LX_ADDR[i] & 32'hFFFF_FFFC); end
      @(negedge clk); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = LX_RDATA[i]; #1;
      @(negedge clk); dmem_rvalid = 1'b0; ld_req = 1'b0; #1;
      checks++; if (done !== 1'b1 || ld_data !== LX_EXP[i]) begin errors++; $display("FAIL ld_ext_data[%0d]: done %b data %h want 1 %h", i, done, ld_data, LX_EXP[i]); end
    end
  endtask

  task automatic test_store_delayed();
    @(negedge clk); st_req = 1'b1; lsu_op = 3'b001; addr = 32'h202; st_data = 32'hABCD_1234; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sh_c0_stall: got %b want 1", stall); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); dmem_gnt = (c == 4); #1;
      checks++; if ({dmem_req, dmem_we, stall} !== 3'b111 || dmem_addr !== 32'h200 || dmem_be !== 4'b1100 || dmem_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_req[%0d]: req/we/stall %b addr %h be %b wd %h want 111 200 1100 12341234", c, {dmem_req, dmem_we, stall}, dmem_addr, dmem_be, dmem_wdata); end
    end
    @(negedge clk); dmem_gnt = 1'b0; st_req = 1'b0; #1;
    checks++; if ({done, stall, dmem_req} !== 3'b100 || ld_data !== 32'hCAFE_BABE) begin errors++; $display("FAIL sh_done: done/stall/req %b data %h want 100 cafebabe", {done, stall, dmem_req}, ld_data); end
  endtask

  task automatic test_store_lanes();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); st_req = 1'b1; lsu_op = SL_OP[i]; addr = SL_ADDR[i]; st_data = SL_DATA[i]; #1;
      @(negedge clk); dmem_gnt = 1'b1; #1;
      checks++; if (dmem_we !== 1'b1 || dmem_addr !== SL_WORD[i] || dmem_be !== SL_BE[i] || dmem_wdata !== SL_WD[i]) begin errors++; $display("FAIL st_lane[%0d]: we %b addr %h be %b wd %h want 1 %h %b %h", i, dmem_we, dmem_addr, dmem_be, dmem_wdata, SL_WORD[i], SL_BE[i], SL_WD[i]); end
      @(negedge clk); dmem_gnt = 1'b0; st_req = 1'b0; #1;
      checks++; if ({done, stall} !== 2'b10) begin errors++; $display("FAIL st_done[%0d]: done/stall %b want 10", i, {done, stall}); end
    end
  endtask

  task automatic test_misaligned();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ld_req = MA_LD[i]; st_req = ~MA_LD[i]; lsu_op = MA_OP[i]; addr = MA_ADDR[i]; #1;
      checks++; if ({misaligned, stall, dmem_req} !== 3'b100) begin errors++; $display("FAIL mis_pulse[%0d]: mis/stall/req %b want 100", i, {misaligned, stall, dmem_req}); end
      @(negedge clk); ld_req = 1'b0; st_req = 1'b0; #1;
      checks++; if ({misaligned, dmem_req, done} !== 3'b000) begin errors++; $display("FAIL mis_after[%0d]: mis/req/done %b want 000", i, {misaligned, dmem_req, done}); end
    end
  endtask

  task automatic test_split();
    @(negedge clk); ld_req = 1'b1; lsu_op = 3'b010; addr = 32'h101; #1;
    checks++; if ({stall, misaligned} !== 2'b10) begin errors++; $display("FAIL split_c0: stall/mis %b want 10", {stall, misaligned}); end
    @(negedge clk); dmem_gnt = 1'b1; #1;
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1110) begin errors++; $display("FAIL split_beat1: req %b addr %h be %b want 1 100 1110", dmem_req, dmem_addr, dmem_be); end
    @(negedge clk); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h4433_2211; #1;
    @(negedge clk); dmem_rvalid = 1'b0; dmem_gnt = 1'b1; #1;
    checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h104 || dmem_be !== 4'b0001) begin errors++; $display("FAIL split_beat2: req %b addr %h be %b want 1 104 0001", dmem_req, dmem_addr, dmem_be); end
    @(negedge clk); dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8877_6655; #1;
    @(negedge clk); dmem_rvalid = 1'b0; ld_req = 1'b0; #1;
    checks++; if (done !== 1'b1 || ld_data !== 32'h5544_3322) begin errors++; $display("FAIL split_data: done %b data %h want 1 55443322", done, ld_data); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); ld_req = 1'b1; lsu_op = 3'b010; addr = 32'h500; #1;
    @(negedge clk); dmem_gnt = 1'b1; #1;
    @(negedge clk); dmem_gnt = 1'b0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_wait_stall: got %b want 1", stall); end
    #1 rst_n = 1'b0; #1;
    checks++; if ({stall, done, misaligned, bus_err, dmem_req, dmem_we} !== 6'b0 || ld_data !== 32'h0) begin errors++; $display("FAIL rst_mid_outs: ctrl %b data %h want 000000 0", {stall, done, misaligned, bus_err, dmem_req, dmem_we}, ld_data); end
    @(negedge clk); ld_req = 1'b0; rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h9999_9999; #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); dmem_rvalid = 1'b0; #1;
      checks++; if ({done, dmem_req} !== 2'b00 || ld_data !== 32'h0) begin errors++; $display("FAIL rst_late_rvalid[%0d]: done/req %b data %h want 00 0", c, {done, dmem_req}, ld_data); end
    end
    @(negedge clk); ld_req = 1'b1; addr = 32'h504; #1;
    @(negedge clk); #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_req_pre: req %b want 1", dmem_req); end
    #1 rst_n = 1'b0; #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req_drop: req %b want 0", dmem_req); end
    @(negedge clk); ld_req = 1'b0; rst_n = 1'b1; #1;
  endtask

  task automatic test_timeout();
    @(negedge clk); ld_req = 1'b1; lsu_op = 3'b010; addr = 32'h400;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111; #1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      checks++; if ({dmem_req, done, stall} !== 3'b101) begin errors++; $display("FAIL to_req[%0d]: req/done/stall %b want 101", c, {dmem_req, done, stall}); end
    end
    @(negedge clk); dmem_rvalid = 1'b0; #1;
    checks++; if ({done, bus_err, stall, dmem_req} !== 4'b1100 || ld_data !== 32'h0) begin errors++; $display("FAIL to_done: done/err/stall/req %b data %h want 1100 0", {done, bus_err, stall, dmem_req}, ld_data); end
    @(negedge clk); ld_req = 1'b0; #1;
    checks++; if ({done, bus_err} !== 2'b00) begin errors++; $display("FAIL to_clear: done/err %b want 00", {done, bus_err}); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_load_ext();
    test_store_delayed();
    test_store_lanes();
`ifdef LSU_SPLIT_MISALIGNED_EN
    test_split();
`else
    test_misaligned();
`endif
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle RV32I core, directly downstream of the ALU. It takes the ALU result as the effective address and performs the data-memory access over a req/gnt/rvalid bus. It formats byte enables and store lanes, extracts and extends load data, and stalls the core while a transaction is in flight.

## Interface
- `WAIT_TIMEOUT`, default 255: max cycles spent in REQ+WAIT before bus error; 0 disables the timeout.
- `i_clk`  in  1  core clock
- `i_rst_n`  in  1  reset, asynchronous assert, active-low
- `i_ld_req`  in  1  current instruction is a load
- `i_st_req`  in  1  current instruction is a store
- `i_lsu_op`  in  3  `LSUOp_e`: access size/sign (funct3)
- `i_addr`  in  32  effective address (ALU result)
- `i_st_data`  in  32  store data (rs2)
- `o_stall`  out  1  hold PC/instruction
- `o_done`  out  1  one-cycle completion pulse
- `o_ld_data`  out  32  extended load result, registered
- `o_misaligned`  out  1  one-cycle misalignment exception pulse
- `o_bus_err`  out  1  qualifies `o_done` on timeout
- `o_dmem_req` / `o_dmem_we`  out  1  bus request / write
- `o_dmem_addr`  out  32  word address, bits [1:0] always 0
- `o_dmem_be`  out  4  byte enables
- `o_dmem_wdata`  out  32  lane-aligned store data
- `i_dmem_gnt`  in  1  request accepted
- `i_dmem_rvalid` / `i_dmem_rdata`  in  1/32  read response

## Operation
- FSM states: IDLE, REQ, WAIT, REQ2, WAIT2, DONE.
- **IDLE, no request:** `o_stall`=0.
- **IDLE, `i_ld_req` or `i_st_req`:**
  - Latch addr, op, data, and we.
  - Drive `o_stall`=1 combinationally.
  - Go to REQ.
  - If both requests are high, the load wins.
- **Alignment:** H/HU needs `addr[0]`=0; W needs `addr[1:0]`=0.
  - A misaligned access without split support pulses `o_misaligned`, issues no bus access, and stays in IDLE with `o_stall`=0.
- **REQ:** drive `o_dmem_req`=1 and hold addr/be/wdata stable until `i_dmem_gnt`.
  - On gnt: store goes to DONE (or REQ2 if split); load goes to WAIT.
- **WAIT:** on `i_dmem_rvalid`, capture rdata and go to DONE (or REQ2 if split).
- **REQ2/WAIT2:** second beat, same rules; completion goes to DONE.
- **DONE:** `o_done`=1, `o_stall`=0, then IDLE. The instruction retires this cycle, so no retrigger occurs.
- **Byte enables** (off=`addr[1:0]`): B gives `0001<<off`, H gives `0011<<off`, W gives `1111`.
- **Store lanes:** B is `{4{d[7:0]}}`, H is `{2{d[15:0]}}`, W is `d`.
- **Load extract:** `rdata >> 8*off`, then sign-extend (B/H) or zero-extend (BU/HU) from bit 7/15.
- **Stores:** `o_ld_data` is unchanged.
- **Illegal `i_lsu_op` encodings:** treated as W.
- **Timeout:** counter clears on entry to REQ and on each gnt/rvalid.
  - Reaching `WAIT_TIMEOUT` goes to DONE with `o_bus_err`=1.
  - Loads then write `o_ld_data`=0.
- `i_dmem_rvalid` outside WAIT/WAIT2 is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset mid-transaction: `o_dmem_req` drops asynchronously, the transaction is abandoned, and no `o_done` is produced.
- `rvalid` arrives no earlier than the cycle after gnt.
- Aligned load, gnt first REQ cycle, rvalid next cycle:
  - C0: IDLE, stall.
  - C1: REQ, gnt.
  - C2: WAIT, rvalid.
  - C3: DONE, `o_ld_data` valid. Minimum 3 stall cycles.
- Aligned store: C0 IDLE, C1 REQ+gnt, C2 DONE. Minimum 2 stall cycles.
- `o_ld_data` holds until the next load completes.

## Configuration
- `LSU_SPLIT_MISALIGNED_EN` defined: misaligned H/W accesses become two beats.
  - Beat 1 goes to word A with `be = (mask<<off)[3:0]`.
  - Beat 2 goes to A+4 with `be = (mask<<off)[7:4]`.
  - Address wraps at 0xFFFF_FFFC to 0.
  - Stores use `{hi,lo} = d << 8*off`.
  - Loads compute `{rdata2,rdata1} >> 8*off`.
  - `o_misaligned` is tied to 0.
- Undefined: REQ2/WAIT2 are absent and misaligned accesses trap as above.

## Structure
- `singlecycle_pkg` holds:
  - `LSUOp_e` (B=000, H=001, W=010, BU=100, HU=101).
  - The FSM state enum `LSUState_e`.
- Sub-module `lsu_lane_fmt`: combinational be/wdata generation and load extract/extend; instantiated once in `lsu`.

## Test plan
- LW at 0x100, rdata 0x8000_00F0, gnt immediate, rvalid +1 -> `o_ld_data`=0x8000_00F0, `o_done` at C3, stall C0–C2.
- LB at 0x103, rdata 0x80xx_xxxx -> be=1000, `o_ld_data`=0xFFFF_FF80; LBU -> 0x0000_0080.
- SH 0x1234 at 0x202, gnt delayed 4 cycles -> req/addr 0x200, be=1100, wdata 0x1234_1234 held stable; done 1 cycle after gnt.
- LW at 0x101 without macro -> `o_misaligned` pulse, no `o_dmem_req`. With macro: beats at 0x100/0x104, rdata 0x4433_2211/0x8877_6655 -> 0x5544_3322.
- No gnt, `WAIT_TIMEOUT`=8 -> `o_done`+`o_bus_err` after 8 REQ cycles, `o_ld_data`=0.
- Assert `i_rst_n`=0 in WAIT -> req drops immediately, outputs 0; late rvalid after reset ignored.
